// File: rtl/ikaopm_wrseq_pkg.sv
// Shared types and constants for the IKAOPM write sequencer.
package ikaopm_wrseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_A_SETUP  = 3'd1,
    ST_A_STROBE = 3'd2,
    ST_A_HOLD   = 3'd3,
    ST_D_SETUP  = 3'd4,
    ST_D_STROBE = 3'd5,
    ST_D_HOLD   = 3'd6,
    ST_BUSY     = 3'd7
  } wrseq_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

  localparam logic       BUS_CS_N_IDLE = 1'b1;
  localparam logic       BUS_WR_N_IDLE = 1'b1;
  localparam logic       BUS_A0_RST    = 1'b0;
  localparam logic [7:0] BUS_D_RST     = 8'h00;

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ikaopm_sync_fifo.sv
// Single-clock request queue with flush; a full queue refuses pushes instead of overwriting.
module ikaopm_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  // Flush wins over a same-edge push so the queue ends up truly empty.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge i_EMUCLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ikaopm_write_sequencer.sv
// Replays queued {addr, data} requests as timed two-phase OPM CPU-port writes.
module ikaopm_write_sequencer
  import ikaopm_wrseq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_CYC  = 15,
  parameter int unsigned STROBE_CYC = 20,
  parameter int unsigned HOLD_CYC   = 15,
  parameter int unsigned BUSY_CYC   = 256,
  parameter int unsigned ADDR_CACHE = 1
) (
  input  logic                          i_EMUCLK,
  input  logic                          i_RST,
  input  logic                          i_REQ_VALID,
  output logic                          o_REQ_READY,
  input  logic [7:0]                    i_REQ_ADDR,
  input  logic [7:0]                    i_REQ_DATA,
  input  logic                          i_FLUSH,
  output logic                          o_CS_n,
  output logic                          o_WR_n,
  output logic                          o_A0,
  output logic [7:0]                    o_D,
  output logic [$clog2(FIFO_DEPTH):0]   o_LEVEL,
  output logic                          o_IDLE
);

  localparam int unsigned CW = $clog2(max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC, BUSY_CYC)) + 1;

  wrseq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_zero;
  wr_req_t       cur_q, cur_d;
  logic [7:0]    cache_addr_q, cache_addr_d;
  logic          cache_vld_q, cache_vld_d;
  logic          cs_n_d, wr_n_d, a0_d, idle_d;
  logic [7:0]    d_d;

  wr_req_t       req_in;
  wr_req_t       head;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign req_in      = '{addr: i_REQ_ADDR, data: i_REQ_DATA};
  assign o_REQ_READY = ~fifo_full;
  assign cnt_zero    = (cnt_q == '0);

  ikaopm_sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_EMUCLK (i_EMUCLK),
    .i_RST    (i_RST),
    .push     (i_REQ_VALID),
    .din      (req_in),
    .pop      (pop),
    .flush    (i_FLUSH),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (o_LEVEL)
  );

  // Next state, phase counter and bus levels; bus registers follow the current state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_zero ? cnt_q : cnt_q - CW'(1);
    cur_d        = cur_q;
    cache_addr_d = cache_addr_q;
    cache_vld_d  = cache_vld_q;
    pop          = 1'b0;
    cs_n_d       = BUS_CS_N_IDLE;
    wr_n_d       = BUS_WR_N_IDLE;
    a0_d         = o_A0;
    d_d          = o_D;
    idle_d       = (state_q == ST_IDLE) && fifo_empty;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = head;
          cnt_d = CW'(SETUP_CYC - 1);
          if ((ADDR_CACHE != 0) && cache_vld_q && (head.addr == cache_addr_q))
            state_d = ST_D_SETUP;
          else
            state_d = ST_A_SETUP;
        end
      end
      ST_A_SETUP: begin
        cs_n_d = 1'b0;
        a0_d   = 1'b0;
        d_d    = cur_q.addr;
        if (cnt_zero) begin
          state_d = ST_A_STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
        end
      end
      ST_A_STROBE: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        a0_d   = 1'b0;
        d_d    = cur_q.addr;
        if (cnt_zero) begin
          state_d = ST_A_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end
      end
      ST_A_HOLD: begin
        a0_d = 1'b0;
        d_d  = cur_q.addr;
        if (cnt_zero) begin
          state_d = ST_D_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      ST_D_SETUP: begin
        cs_n_d = 1'b0;
        a0_d   = 1'b1;
        d_d    = cur_q.data;
        if (cnt_zero) begin
          state_d = ST_D_STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
        end
      end
      ST_D_STROBE: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        a0_d   = 1'b1;
        d_d    = cur_q.data;
        if (cnt_zero) begin
          state_d = ST_D_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end
      end
      ST_D_HOLD: begin
        a0_d = 1'b1;
        d_d  = cur_q.data;
        if (cnt_zero) begin
          cache_addr_d = cur_q.addr;
          cache_vld_d  = 1'b1;
          if (BUSY_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(BUSY_CYC - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      o_CS_n       <= BUS_CS_N_IDLE;
      o_WR_n       <= BUS_WR_N_IDLE;
      o_A0         <= BUS_A0_RST;
      o_D          <= BUS_D_RST;
      o_IDLE       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      cache_addr_q <= cache_addr_d;
      cache_vld_q  <= cache_vld_d;
      o_CS_n       <= cs_n_d;
      o_WR_n       <= wr_n_d;
      o_A0         <= a0_d;
      o_D          <= d_d;
      o_IDLE       <= idle_d;
    end
  end

endmodule

// File: tb/tb_ikaopm_write_sequencer.sv
// Directed bench for the IKAOPM write sequencer with default timing parameters.
module tb_ikaopm_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       flush;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;
  logic [4:0] level;
  logic       idle;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ikaopm_write_sequencer dut (
    .i_EMUCLK    (clk),
    .i_RST       (rst),
    .i_REQ_VALID (req_valid),
    .o_REQ_READY (req_ready),
    .i_REQ_ADDR  (req_addr),
    .i_REQ_DATA  (req_data),
    .i_FLUSH     (flush),
    .o_CS_n      (cs_n),
    .o_WR_n      (wr_n),
    .o_A0        (a0),
    .o_D         (d),
    .o_LEVEL     (level),
    .o_IDLE      (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: one entry per falling edge of WR_n.
  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         t;
  } ev_t;
  ev_t  evq[$];
  ev_t  ev;
  logic prev_wr = 1'b1;

  always @(negedge clk) begin
    if (prev_wr === 1'b1 && wr_n === 1'b0) begin
      ev.a0 = a0;
      ev.d  = d;
      ev.t  = cyc;
      evq.push_back(ev);
    end
    prev_wr = wr_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] v);
    req_addr  = a;
    req_data  = v;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    tick();
    tick();
    for (int k = 0; k < budget; k++) begin
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_strobe(input logic want_a0, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (cs_n === 1'b0 && wr_n === 1'b0 && a0 === want_a0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 8'h00;
    req_data  = 8'h00;
    flush     = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({cs_n, wr_n, a0, d} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_bus: cs/wr/a0/d=%b/%b/%b/%h expected 1/1/0/00", cs_n, wr_n, a0, d);
    end
    n_tests++;
    if ({level, idle, req_ready} !== {5'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_status: level/idle/ready=%0d/%b/%b expected 0/1/1", level, idle, req_ready);
    end
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic test_single_write();
    int n0, bad, first_bad, cs_fall, idle_rise, t, u;
    logic ecs, ewr, ea0, eidle;
    logic [7:0] ed;
    logic [11:0] got_v, exp_v;
    do_reset();
    push(8'h18, 8'hFF);
    n0 = cyc;
    bad = 0; first_bad = -1; cs_fall = -1; idle_rise = -1;
    got_v = '0; exp_v = '0;
    for (int k = 1; k <= 360; k++) begin
      tick();
      t = k - 2;
      if (t < 0) begin
        ecs = 1'b1; ewr = 1'b1; ea0 = 1'b0; ed = 8'h00;
      end else if (t >= 100) begin
        ecs = 1'b1; ewr = 1'b1; ea0 = 1'b1; ed = 8'hFF;
      end else begin
        u   = t % 50;
        ea0 = (t >= 50);
        ed  = ea0 ? 8'hFF : 8'h18;
        ecs = (u >= 35);
        ewr = !(u >= 15 && u < 35);
      end
      eidle = (k >= 358);
      if (cs_fall < 0 && cs_n === 1'b0) cs_fall = k;
      if (idle_rise < 0 && idle === 1'b1) idle_rise = k;
      if ({cs_n, wr_n, a0, d, idle} !== {ecs, ewr, ea0, ed, eidle}) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = k;
          got_v = {cs_n, wr_n, a0, d, idle};
          exp_v = {ecs, ewr, ea0, ed, eidle};
        end
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL single_trace: %0d cycles differ, first at push+%0d got cs,wr,a0,d,idle=%b expected %b",
               bad, first_bad, got_v, exp_v);
    end
    n_tests++;
    if (cs_fall !== 2) begin
      n_fail++;
      $display("FAIL single_cs_latency: CS_n fell at push+%0d expected push+2", cs_fall);
    end
    n_tests++;
    if (idle_rise - cs_fall !== 356) begin
      n_fail++;
      $display("FAIL single_idle_return: idle rose %0d cycles after CS_n fall expected 356", idle_rise - cs_fall);
    end
    n_tests++;
    if (evq.size() !== 2) begin
      n_fail++;
      $display("FAIL single_strobe_count: %0d strobes expected 2", evq.size());
    end else begin
      n_tests++;
      if ({evq[0].a0, evq[0].d, evq[1].a0, evq[1].d} !== {1'b0, 8'h18, 1'b1, 8'hFF}) begin
        n_fail++;
        $display("FAIL single_strobe_values: %b/%h %b/%h expected 0/18 1/FF",
                 evq[0].a0, evq[0].d, evq[1].a0, evq[1].d);
      end
      n_tests++;
      if (evq[1].t - evq[0].t !== 50) begin
        n_fail++;
        $display("FAIL single_strobe_spacing: %0d expected 50", evq[1].t - evq[0].t);
      end
    end
  endtask

  task automatic test_addr_cache();
    bit ok;
    do_reset();
    push(8'h08, 8'h08);
    push(8'h08, 8'h47);
    wait_idle(3000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cache_timeout: idle not reached, got 0 expected 1");
    end
    n_tests++;
    if (evq.size() !== 3) begin
      n_fail++;
      $display("FAIL cache_strobe_count: %0d strobes expected 3", evq.size());
    end else begin
      n_tests++;
      if ({evq[0].a0, evq[0].d, evq[1].a0, evq[1].d, evq[2].a0, evq[2].d}
          !== {1'b0, 8'h08, 1'b1, 8'h08, 1'b1, 8'h47}) begin
        n_fail++;
        $display("FAIL cache_strobe_values: %b/%h %b/%h %b/%h expected 0/08 1/08 1/47",
                 evq[0].a0, evq[0].d, evq[1].a0, evq[1].d, evq[2].a0, evq[2].d);
      end
      n_tests++;
      if (evq[2].t - evq[1].t !== 307) begin
        n_fail++;
        $display("FAIL cache_data_gap: %0d expected 307", evq[2].t - evq[1].t);
      end
    end
  endtask

  task automatic test_overflow();
    int i, guard, ready_bad, bad_seq;
    bit saw_full, full_ready, acc, ok;
    logic [4:0] max_level;
    do_reset();
    push(8'h20, 8'h80);
    tick();
    tick();
    i = 1; guard = 0; ready_bad = 0; saw_full = 1'b0; full_ready = 1'b1; max_level = '0;
    while (i <= 17 && guard < 20000) begin
      req_addr  = 8'(8'h20 + i);
      req_data  = 8'(8'h80 + i);
      req_valid = 1'b1;
      acc = req_ready;
      if (level > max_level) max_level = level;
      if (level < 5'd16 && req_ready !== 1'b1) ready_bad++;
      if (level == 5'd16 && !saw_full) begin
        saw_full   = 1'b1;
        full_ready = req_ready;
      end
      tick();
      guard++;
      if (acc) i++;
    end
    req_valid = 1'b0;
    n_tests++;
    if (!saw_full || full_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_ready_drop: saw_full=%b ready_at_16=%b expected 1/0", saw_full, full_ready);
    end
    n_tests++;
    if (max_level !== 5'd16 || ready_bad !== 0) begin
      n_fail++;
      $display("FAIL overflow_level: max=%0d ready_bad=%0d expected 16/0", max_level, ready_bad);
    end
    wait_idle(20000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL overflow_timeout: idle not reached, got 0 expected 1");
    end
    n_tests++;
    if (evq.size() !== 36) begin
      n_fail++;
      $display("FAIL overflow_strobe_count: %0d strobes expected 36", evq.size());
    end else begin
      bad_seq = 0;
      for (int k = 0; k < 18; k++) begin
        if ({evq[2*k].a0, evq[2*k].d, evq[2*k+1].a0, evq[2*k+1].d}
            !== {1'b0, 8'(8'h20 + k), 1'b1, 8'(8'h80 + k)}) bad_seq++;
      end
      n_tests++;
      if (bad_seq !== 0) begin
        n_fail++;
        $display("FAIL overflow_order: %0d writes out of order or corrupted expected 0", bad_seq);
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    int cs_low;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_addr  = 8'(8'h40 + k);
      req_data  = 8'(8'h90 + k);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    n_tests++;
    if (level !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_prefill: level=%0d expected 5", level);
    end
    wait_strobe(1'b0, 200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_wait_astrobe: address strobe not seen, got 0 expected 1");
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (level !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_level: level=%0d expected 0", level);
    end
    wait_idle(2000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_timeout: idle not reached, got 0 expected 1");
    end
    n_tests++;
    if (evq.size() !== 2) begin
      n_fail++;
      $display("FAIL flush_strobe_count: %0d strobes expected 2", evq.size());
    end else begin
      n_tests++;
      if ({evq[0].a0, evq[0].d, evq[1].a0, evq[1].d} !== {1'b0, 8'h40, 1'b1, 8'h90}) begin
        n_fail++;
        $display("FAIL flush_inflight: %b/%h %b/%h expected 0/40 1/90",
                 evq[0].a0, evq[0].d, evq[1].a0, evq[1].d);
      end
    end
    cs_low = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (cs_n !== 1'b1) cs_low++;
    end
    n_tests++;
    if (cs_low !== 0) begin
      n_fail++;
      $display("FAIL flush_quiet_bus: CS_n low on %0d cycles expected 0", cs_low);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    do_reset();
    push(8'h30, 8'h11);
    wait_strobe(1'b1, 300, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_wait_dstrobe: data strobe not seen, got 0 expected 1");
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({cs_n, wr_n, a0, d} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_bus: cs/wr/a0/d=%b/%b/%b/%h expected 1/1/0/00", cs_n, wr_n, a0, d);
    end
    n_tests++;
    if ({level, idle} !== {5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_status: level/idle=%0d/%b expected 0/1", level, idle);
    end
    rst = 1'b0;
    evq.delete();
    push(8'h30, 8'h22);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_timeout: idle not reached, got 0 expected 1");
    end
    n_tests++;
    if (evq.size() !== 2) begin
      n_fail++;
      $display("FAIL rstmid_cache_invalid: %0d strobes expected 2", evq.size());
    end else begin
      n_tests++;
      if ({evq[0].a0, evq[0].d, evq[1].a0, evq[1].d} !== {1'b0, 8'h30, 1'b1, 8'h22}) begin
        n_fail++;
        $display("FAIL rstmid_rewrite: %b/%h %b/%h expected 0/30 1/22",
                 evq[0].a0, evq[0].d, evq[1].a0, evq[1].d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_addr_cache();
    test_overflow();
    test_flush();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
